// File: rtl/spi_slave_mode_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_slave_mode_if
//  Purpose  : Bundle of SPI host pins and the word-level RX/TX handshake seen
//             by the register/command decoder. The slave modport is the
//             view of spi_slave_mode; the master modport is the opposite side.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_slave_mode_if #(
  parameter int unsigned WIDTH = 8
);
  // Host pins
  logic             spi_clk;
  logic             spi_mosi;
  logic             spi_cs;
  logic             spi_miso;
  logic             spi_miso_oe;
  // Word-level side
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic             tx_underrun;
  logic             abort;

  modport slave (
    input  spi_clk, spi_mosi, spi_cs, tx_data, tx_load,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, abort
  );

  modport master (
    output spi_clk, spi_mosi, spi_cs, tx_data, tx_load,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, abort
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_mode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_slave_mode
//  Purpose  : Parametrised full-duplex SPI slave. Host pins are synchronised
//             into the clk_i domain by 3-flop chains and edge-detected there,
//             so clk_i must run at least 8x the SPI clock. Provides received
//             words with a one-cycle valid pulse, a one-word TX holding
//             buffer, underrun fill and mid-word abort reporting.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_mode #(
  parameter int unsigned      WIDTH         = 8,     // bits per word, 2..32
  parameter bit               CPOL          = 1'b0,  // SPI clock idle level
  parameter bit               CPHA          = 1'b0,  // 0: sample leading edge
  parameter bit               MSB_FIRST     = 1'b1,  // 1: MSB shifted first
  parameter logic [WIDTH-1:0] UNDERRUN_FILL = '1     // sent when TX is empty
) (
  input wire              clk_i,
  input wire              rst_ni,
  spi_slave_mode_if.slave bus
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]       sclk_q;
  logic [2:0]       mosi_q;
  logic [2:0]       cs_q;

  state_e           state_q;
  logic             oe_q;

  logic [CW-1:0]    count_q,    count_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             abort_q,    abort_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q,     hold_d;
  logic             tx_ready_q, tx_ready_d;
  logic             underrun_q, underrun_d;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic             lead_edge;
  logic             trail_edge;
  logic             sample_edge;
  logic             shift_edge;
  logic             cs_high;
  logic             mosi_bit;
  logic             in_frame;
  logic             do_sample;
  logic             do_shift;
  logic             frame_start;
  logic             frame_end;
  logic             load_point;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shifted;
  logic             miso_bit;

  // Oldest stage [2] is the previous level, stage [1] the newer one.
  assign lead_edge   = (sclk_q[2] == CPOL) && (sclk_q[1] != CPOL);
  assign trail_edge  = (sclk_q[2] != CPOL) && (sclk_q[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign cs_high     = cs_q[2];
  assign mosi_bit    = mosi_q[2];

  // Edges coinciding with CS seen high, or arriving while idle, are ignored.
  assign in_frame    = (state_q == ST_ACTIVE) && !cs_high;
  assign do_sample   = in_frame && sample_edge;
  assign do_shift    = in_frame && shift_edge;
  assign frame_start = (state_q == ST_IDLE) && !cs_high;
  assign frame_end   = (state_q == ST_ACTIVE) && cs_high;

  // A shift edge with the counter at zero always opens a new word: for CPHA=1
  // it is the first edge of the word, for CPHA=0 it follows the final sample
  // edge of the previous word. CPHA=0 additionally needs the first bit on
  // MISO before any clock edge, hence the load at CS fall.
  assign load_point  = (do_shift && (count_q == '0)) ||
                       (!CPHA && frame_start);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign rx_next    = {rx_shift_q[WIDTH-2:0], mosi_bit};
      assign tx_shifted = {tx_shift_q[WIDTH-2:0], 1'b0};
      assign miso_bit   = tx_shift_q[WIDTH-1];
    end else begin : g_lsb_first
      assign rx_next    = {mosi_bit, rx_shift_q[WIDTH-1:1]};
      assign tx_shifted = {1'b0, tx_shift_q[WIDTH-1:1]};
      assign miso_bit   = tx_shift_q[0];
    end
  endgenerate

  // Bring the asynchronous host pins into the clk_i domain, preset to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= {3{CPOL}};
      mosi_q <= 3'b000;
      cs_q   <= 3'b111;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_clk};
      mosi_q <= {mosi_q[1:0], bus.spi_mosi};
      cs_q   <= {cs_q[1:0], bus.spi_cs};
    end
  end

  // Frame state machine; MISO output enable tracks the ACTIVE state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      oe_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cs_high) begin
            state_q <= ST_ACTIVE;
            oe_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_high) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for the receive path, transmit path and status pulses.
  always_comb begin
    count_d    = count_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    underrun_d = 1'b0;

    // CS rising: partial words are dropped; only a non-zero count is an abort.
    if (frame_end) begin
      abort_d    = (count_q != '0);
      count_d    = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end

    if (do_sample) begin
      rx_shift_d = rx_next;
      if (count_q == LAST_BIT) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
        count_d    = '0;
      end else begin
        count_d    = count_q + 1'b1;
      end
    end

    if (load_point) begin
      if (!tx_ready_q) begin
        // Holding register occupied: move it into the shifter.
        tx_shift_d = hold_q;
        tx_ready_d = 1'b1;
      end else if (bus.tx_load) begin
        // Word arrives exactly at the load point: bypass the holding register.
        tx_shift_d = bus.tx_data;
      end else begin
        tx_shift_d = UNDERRUN_FILL;
        underrun_d = 1'b1;
      end
    end else begin
      if (do_shift) begin
        tx_shift_d = tx_shifted;
      end
      // A load while the holding register is full is dropped.
      if (bus.tx_load && tx_ready_q) begin
        hold_d     = bus.tx_data;
        tx_ready_d = 1'b0;
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.spi_miso    = miso_bit;
  assign bus.spi_miso_oe = oe_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.abort       = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_mode
//  Purpose  : Scoreboard bench for spi_slave_mode. One instance runs mode 0,
//             8-bit MSB first; the other mode 3, 16-bit LSB first.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_mode;

  localparam int H = 8;  // SPI half period in clk cycles

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_mode_if #(.WIDTH(8))  if0 ();
  spi_slave_mode_if #(.WIDTH(16)) if3 ();

  spi_slave_mode #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if0.slave)
  );

  spi_slave_mode #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_m3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if3.slave)
  );

  int total  = 0;
  int passed = 0;
  int und0 = 0, abt0 = 0, und3 = 0, abt3 = 0;

  logic [7:0]  exp_rx0[$], exp_miso0[$], got_miso0[$];
  logic [15:0] exp_rx3[$], exp_miso3[$], got_miso3[$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a word.
  always @(negedge clk) begin
    if (if0.rx_valid === 1'b1) begin
      if (exp_rx0.size() == 0) begin
        total++;
        $display("FAIL rx0_unexpected: got 0x%0h expected no word", if0.rx_data);
      end else chk("rx0_word", 32'(if0.rx_data), 32'(exp_rx0.pop_front()));
    end
    if (if3.rx_valid === 1'b1) begin
      if (exp_rx3.size() == 0) begin
        total++;
        $display("FAIL rx3_unexpected: got 0x%0h expected no word", if3.rx_data);
      end else chk("rx3_word", 32'(if3.rx_data), 32'(exp_rx3.pop_front()));
    end
    if (got_miso0.size() > 0) begin
      if (exp_miso0.size() == 0) begin
        total++;
        $display("FAIL miso0_unexpected: got 0x%0h expected no word", got_miso0.pop_front());
      end else chk("miso0_word", 32'(got_miso0.pop_front()), 32'(exp_miso0.pop_front()));
    end
    if (got_miso3.size() > 0) begin
      if (exp_miso3.size() == 0) begin
        total++;
        $display("FAIL miso3_unexpected: got 0x%0h expected no word", got_miso3.pop_front());
      end else chk("miso3_word", 32'(got_miso3.pop_front()), 32'(exp_miso3.pop_front()));
    end
    if (if0.tx_underrun === 1'b1) und0++;
    if (if0.abort === 1'b1)       abt0++;
    if (if3.tx_underrun === 1'b1) und3++;
    if (if3.abort === 1'b1)       abt3++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [7:0] d);
    if0.tx_data = d; if0.tx_load = 1'b1;
    tick(1);
    if0.tx_load = 1'b0;
  endtask

  task automatic m0_cs_fall();
    tick(1);
    if0.spi_cs = 1'b0;
  endtask

  // Mode 0 host: MOSI set before each rising edge, MISO captured at the rise.
  // The frame ends by raising CS with SCLK still high, then returning SCLK low.
  task automatic m0_bits(input logic [7:0] d, input int nbits);
    logic [7:0] cap;
    cap = '0;
    if0.spi_mosi = d[7];
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      if0.spi_clk = 1'b1;
      cap[7-i] = if0.spi_miso;
      tick(H);
      if (i < nbits - 1) begin
        if0.spi_clk  = 1'b0;
        if0.spi_mosi = d[6-i];
        tick(H);
      end
    end
    if0.spi_cs = 1'b1;
    tick(H);
    if0.spi_clk = 1'b0;
    tick(H);
    if (nbits == 8) got_miso0.push_back(cap);
  endtask

  // Mode 3 host: two LSB-first words back to back under one CS.
  task automatic m3_frame(input logic [15:0] w0, input logic [15:0] w1);
    logic [15:0] cap;
    logic [15:0] w;
    if3.spi_cs = 1'b0;
    tick(H);
    for (int k = 0; k < 2; k++) begin
      w   = (k == 0) ? w0 : w1;
      cap = '0;
      for (int i = 0; i < 16; i++) begin
        if3.spi_clk  = 1'b0;
        if3.spi_mosi = w[i];
        tick(H);
        if3.spi_clk = 1'b1;
        cap[i] = if3.spi_miso;
        tick(H);
      end
      got_miso3.push_back(cap);
    end
    if3.spi_cs = 1'b1;
    tick(H);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.spi_clk = 1'b0; if0.spi_mosi = 1'b0; if0.spi_cs = 1'b1;
    if0.tx_data = '0;   if0.tx_load  = 1'b0;
    if3.spi_clk = 1'b1; if3.spi_mosi = 1'b0; if3.spi_cs = 1'b1;
    if3.tx_data = '0;   if3.tx_load  = 1'b0;
    rst_n = 1'b0;
    tick(3);

    // Reset values
    chk("rst_rx_data",  32'(if0.rx_data),     32'h0);
    chk("rst_rx_valid", 32'(if0.rx_valid),    32'h0);
    chk("rst_tx_ready", 32'(if0.tx_ready),    32'h1);
    chk("rst_miso",     32'(if0.spi_miso),    32'h0);
    chk("rst_oe",       32'(if0.spi_miso_oe), 32'h0);
    chk("rst_underrun", 32'(if0.tx_underrun), 32'h0);
    chk("rst_abort",    32'(if0.abort),       32'h0);
    chk("rst_tx_ready3",32'(if3.tx_ready),    32'h1);
    rst_n = 1'b1;
    tick(3);

    // Mode 0: preloaded 0xA5 out, 0x3C in
    load0(8'hA5);
    chk("preload_ready", 32'(if0.tx_ready), 32'h0);
    exp_rx0.push_back(8'h3C); exp_miso0.push_back(8'hA5);
    m0_cs_fall();
    tick(5);
    chk("active_oe",    32'(if0.spi_miso_oe), 32'h1);
    chk("loaded_ready", 32'(if0.tx_ready),    32'h1);
    m0_bits(8'h3C, 8);
    tick(2);
    chk("t1_underruns", 32'(und0), 32'd0);
    chk("idle_oe",      32'(if0.spi_miso_oe), 32'h0);

    // No preload: fill word and one underrun
    exp_rx0.push_back(8'h5A); exp_miso0.push_back(8'hFF);
    m0_cs_fall();
    m0_bits(8'h5A, 8);
    tick(2);
    chk("t2_underruns", 32'(und0), 32'd1);

    // Abort after 5 bits, then a clean 0x81 frame
    m0_cs_fall();
    m0_bits(8'hF0, 5);
    tick(2);
    chk("abort_count",  32'(abt0), 32'd1);
    chk("abort_und",    32'(und0), 32'd2);
    chk("abort_miso",   32'(if0.spi_miso), 32'h0);
    exp_rx0.push_back(8'h81); exp_miso0.push_back(8'hFF);
    m0_cs_fall();
    m0_bits(8'h81, 8);
    tick(2);
    chk("post_abort_und",   32'(und0), 32'd3);
    chk("post_abort_abort", 32'(abt0), 32'd1);

    // TX_LOAD exactly at the load point with empty holding register
    exp_rx0.push_back(8'hC3); exp_miso0.push_back(8'h55);
    m0_cs_fall();
    tick(3);
    if0.tx_data = 8'h55; if0.tx_load = 1'b1;
    tick(1);
    if0.tx_load = 1'b0;
    chk("bypass_ready", 32'(if0.tx_ready), 32'h1);
    load0(8'h66);
    chk("hold_ready",   32'(if0.tx_ready), 32'h0);
    load0(8'h77);
    chk("ignored_ready",32'(if0.tx_ready), 32'h0);
    m0_bits(8'hC3, 8);
    tick(2);
    chk("bypass_und",   32'(und0), 32'd3);
    exp_rx0.push_back(8'h18); exp_miso0.push_back(8'h66);
    m0_cs_fall();
    m0_bits(8'h18, 8);
    tick(2);
    chk("held_ready",   32'(if0.tx_ready), 32'h1);
    chk("held_und",     32'(und0), 32'd3);

    // Mode 3, 16-bit LSB first, two words under one CS
    if3.tx_data = 16'hC3A5; if3.tx_load = 1'b1;
    tick(1);
    if3.tx_load = 1'b0;
    chk("m3_preload_ready", 32'(if3.tx_ready), 32'h0);
    exp_rx3.push_back(16'h1234); exp_rx3.push_back(16'hBEEF);
    exp_miso3.push_back(16'hC3A5); exp_miso3.push_back(16'hFFFF);
    m3_frame(16'h1234, 16'hBEEF);
    tick(4);
    chk("m3_ready", 32'(if3.tx_ready),    32'h1);
    chk("m3_und",   32'(und3),            32'd1);
    chk("m3_abort", 32'(abt3),            32'd0);
    chk("m3_oe",    32'(if3.spi_miso_oe), 32'h0);

    // Asynchronous reset mid-word
    m0_cs_fall();
    tick(H);
    load0(8'h99);
    for (int i = 0; i < 3; i++) begin
      if0.spi_clk = 1'b1; tick(H);
      if0.spi_clk = 1'b0; tick(H);
    end
    chk("pre_rst_und", 32'(und0), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rx_data",  32'(if0.rx_data),     32'h0);
    chk("arst_tx_ready", 32'(if0.tx_ready),    32'h1);
    chk("arst_oe",       32'(if0.spi_miso_oe), 32'h0);
    chk("arst_miso",     32'(if0.spi_miso),    32'h0);
    chk("arst_rx_valid", 32'(if0.rx_valid),    32'h0);
    chk("arst_rx3_data", 32'(if3.rx_data),     32'h0);
    if0.spi_cs = 1'b1; if0.spi_clk = 1'b0; if0.spi_mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    exp_rx0.push_back(8'hE7); exp_miso0.push_back(8'hFF);
    m0_cs_fall();
    m0_bits(8'hE7, 8);
    tick(4);
    chk("post_rst_und",   32'(und0), 32'd5);
    chk("post_rst_abort", 32'(abt0), 32'd1);

    // Every expectation consumed
    chk("rx0_pending",   32'(exp_rx0.size()),   32'd0);
    chk("miso0_pending", 32'(exp_miso0.size()), 32'd0);
    chk("rx3_pending",   32'(exp_rx3.size()),   32'd0);
    chk("miso3_pending", 32'(exp_miso3.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
